// File: rtl/gigatron_vga_capture.sv
// gigatron_vga_capture
//
// Captures the Gigatron's 160x480 (pixel-strobe domain) video output into a
// 640x480 byte framebuffer. Each Gigatron pixel is replicated into four
// horizontally adjacent framebuffer bytes, written one every other cycle
// because the framebuffer port accepts one write per two cycles.
//
// Ports
//   fpga_clock                 sole clock, all logic on posedge
//   rst                        synchronous active-high reset
//   gigatron_pixel_strobe      one-cycle pulse per Gigatron pixel
//   gigatron_out[7:0]          {vsync_n, hsync_n, B[1:0], G[1:0], R[1:0]}
//   framebuffer_write_signal   one-cycle write request
//   framebuffer_write_address  byte address 0..0x4AFFF
//   framebuffer_write_data     pixel, RRRGGGBB
//   capture_frame_done         one-cycle pulse per vsync_n falling edge
//   capture_overflow           sticky: a visible pixel was dropped
//
// Parameters
//   H_BACK_PORCH  strobes from hsync_n rising to first visible pixel
//   V_BACK_PORCH  lines from vsync_n deassertion to first visible line
//
// Build option
//   GIGATRON_CAPTURE_TEST_PATTERN_EN  when defined, write data is x XOR y
//   instead of the converted pixel colour; addressing is unchanged.
//
// Replicator FSM
//   state | meaning
//   IDLE  | no entry in flight, waiting for a visible strobe
//   BUSY  | replicating the current entry; phase 0..7, write on even phases

module gigatron_vga_capture #(
  parameter int H_BACK_PORCH = 12,
  parameter int V_BACK_PORCH = 33
) (
  input  logic        fpga_clock,
  input  logic        rst,
  input  logic        gigatron_pixel_strobe,
  input  logic [7:0]  gigatron_out,
  output logic        framebuffer_write_signal,
  output logic [18:0] framebuffer_write_address,
  output logic [7:0]  framebuffer_write_data,
  output logic        capture_frame_done,
  output logic        capture_overflow
);

  localparam logic [9:0]  H_FIRST        = 10'(H_BACK_PORCH);
  localparam logic [9:0]  H_LAST         = 10'(H_BACK_PORCH + 159);
  localparam logic [9:0]  V_FIRST        = 10'(V_BACK_PORCH);
  localparam logic [9:0]  V_LAST         = 10'(V_BACK_PORCH + 479);
  localparam logic [9:0]  COUNT_MAX      = 10'd1023;
  localparam logic [18:0] LINE_STRIDE    = 19'd640;
  localparam logic [18:0] LAST_LINE_BASE = 19'(479 * 640);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Sync tracking and raster position
  // ---------------------------------------------------------------------
  logic        hsync_n;
  logic        vsync_n;
  logic        prev_hsync_n;
  logic        prev_vsync_n;
  logic        h_fall;
  logic        v_fall;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [18:0] line_base;
  logic        frame_armed;
  logic        h_in_range;
  logic        v_in_range;
  logic        pixel_visible;
  logic [7:0]  pix_x;
  logic [18:0] entry_base;
  logic [7:0]  entry_data;

  assign hsync_n = gigatron_out[6];
  assign vsync_n = gigatron_out[7];

  assign h_fall = gigatron_pixel_strobe & prev_hsync_n & ~hsync_n;
  assign v_fall = gigatron_pixel_strobe & prev_vsync_n & ~vsync_n;

  // Position tests use the counters as they stand before this strobe's update.
  assign h_in_range = (h_count >= H_FIRST) && (h_count <= H_LAST);
  assign v_in_range = (v_count >= V_FIRST) && (v_count <= V_LAST);

  // frame_armed keeps a frame that started before reset from being captured
  // part-way through; it is set by the next vsync_n falling edge.
  assign pixel_visible = gigatron_pixel_strobe & hsync_n & vsync_n &
                         h_in_range & v_in_range & frame_armed;

  assign pix_x      = 8'(h_count - H_FIRST);
  assign entry_base = line_base + {9'd0, pix_x, 2'b00};

`ifdef GIGATRON_CAPTURE_TEST_PATTERN_EN
  logic [7:0] pix_y;
  assign pix_y      = 8'(v_count - V_FIRST);
  assign entry_data = pix_x ^ pix_y;
`else
  // 2-bit channels widened by repeating the MSB: RRR GGG BB.
  assign entry_data = {gigatron_out[1], gigatron_out[0], gigatron_out[1],
                       gigatron_out[3], gigatron_out[2], gigatron_out[3],
                       gigatron_out[5], gigatron_out[4]};
`endif

  always_ff @(posedge fpga_clock) begin
    if (rst) begin
      prev_hsync_n <= 1'b1;
      prev_vsync_n <= 1'b1;
      h_count      <= '0;
      v_count      <= '0;
      line_base    <= '0;
      frame_armed  <= 1'b0;
    end else if (gigatron_pixel_strobe) begin
      prev_hsync_n <= hsync_n;
      prev_vsync_n <= vsync_n;

      if (!hsync_n) begin
        h_count <= '0;
      end else if (h_count != COUNT_MAX) begin
        h_count <= h_count + 10'd1;
      end

      if (!vsync_n) begin
        v_count <= '0;
      end else if (h_fall && (v_count != COUNT_MAX)) begin
        v_count <= v_count + 10'd1;
      end

      // vsync low wins over a coincident hsync fall, so no stride is added.
      if (!vsync_n) begin
        line_base <= '0;
      end else if (h_fall && v_in_range && frame_armed &&
                   (line_base != LAST_LINE_BASE)) begin
        line_base <= line_base + LINE_STRIDE;
      end

      if (v_fall) begin
        frame_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clock) begin
    if (rst) begin
      capture_frame_done <= 1'b0;
    end else begin
      capture_frame_done <= v_fall;
    end
  end

  // ---------------------------------------------------------------------
  // Replicator FSM
  // ---------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [2:0]  phase_q;
  logic [2:0]  phase_d;

  logic [18:0] cur_base;
  logic [7:0]  cur_data;
  logic [18:0] hold_base;
  logic [7:0]  hold_data;
  logic        hold_valid;

  logic        phase_last;
  logic        load_new;
  logic        load_held;
  logic        hold_capture;
  logic        drop_pixel;

  assign phase_last = (state_q == ST_BUSY) && (phase_q == 3'd7);

  // On the last phase with nothing held, a new pixel goes straight into the
  // current entry; timing is identical to passing through the holding slot.
  assign load_new     = pixel_visible &&
                        ((state_q == ST_IDLE) || (phase_last && !hold_valid));
  assign load_held    = phase_last && hold_valid;
  assign hold_capture = pixel_visible && (state_q == ST_BUSY) &&
                        !phase_last && !hold_valid;
  // A full holding slot drops the pixel even on the last phase: the slot is
  // only freed by that same edge.
  assign drop_pixel   = pixel_visible && (state_q == ST_BUSY) && hold_valid;

  always_ff @(posedge fpga_clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (load_new) begin
          state_d = ST_BUSY;
          phase_d = 3'd0;
        end
      end
      ST_BUSY: begin
        if (phase_q != 3'd7) begin
          phase_d = phase_q + 3'd1;
        end else if (hold_valid || pixel_visible) begin
          phase_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
          phase_d = 3'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    framebuffer_write_signal  = 1'b0;
    framebuffer_write_address = '0;
    framebuffer_write_data    = '0;
    if (state_q == ST_BUSY) begin
      framebuffer_write_signal  = ~phase_q[0];
      framebuffer_write_address = cur_base + {17'd0, phase_q[2:1]};
      framebuffer_write_data    = cur_data;
    end
  end

  always_ff @(posedge fpga_clock) begin
    if (rst) begin
      cur_base         <= '0;
      cur_data         <= '0;
      hold_base        <= '0;
      hold_data        <= '0;
      hold_valid       <= 1'b0;
      capture_overflow <= 1'b0;
    end else begin
      if (load_new) begin
        cur_base <= entry_base;
        cur_data <= entry_data;
      end else if (load_held) begin
        cur_base   <= hold_base;
        cur_data   <= hold_data;
        hold_valid <= 1'b0;
      end

      if (hold_capture) begin
        hold_base  <= entry_base;
        hold_data  <= entry_data;
        hold_valid <= 1'b1;
      end

      if (drop_pixel) begin
        capture_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gigatron_vga_capture.sv
module tb_gigatron_vga_capture;

  logic        fpga_clock = 1'b0;
  logic        rst;
  logic        gigatron_pixel_strobe;
  logic [7:0]  gigatron_out;
  logic        framebuffer_write_signal;
  logic [18:0] framebuffer_write_address;
  logic [7:0]  framebuffer_write_data;
  logic        capture_frame_done;
  logic        capture_overflow;

`ifdef GIGATRON_CAPTURE_TEST_PATTERN_EN
  localparam bit PATTERN_MODE = 1'b1;
`else
  localparam bit PATTERN_MODE = 1'b0;
`endif

  gigatron_vga_capture dut (
    .fpga_clock               (fpga_clock),
    .rst                      (rst),
    .gigatron_pixel_strobe    (gigatron_pixel_strobe),
    .gigatron_out             (gigatron_out),
    .framebuffer_write_signal (framebuffer_write_signal),
    .framebuffer_write_address(framebuffer_write_address),
    .framebuffer_write_data   (framebuffer_write_data),
    .capture_frame_done       (capture_frame_done),
    .capture_overflow         (capture_overflow)
  );

  always #5 fpga_clock = ~fpga_clock;

  int cyc = 0;
  always @(posedge fpga_clock) cyc <= cyc + 1;

  logic [18:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];
  int          done_q[$];

  always @(negedge fpga_clock) begin
    if (framebuffer_write_signal) begin
      wa_q.push_back(framebuffer_write_address);
      wd_q.push_back(framebuffer_write_data);
      wc_q.push_back(cyc);
    end
    if (capture_frame_done) done_q.push_back(cyc);
  end

  int total = 0;
  int bad   = 0;
  int last_strobe = 0;

  typedef struct {
    logic [7:0]  out;
    logic [18:0] exp_base;
    logic [7:0]  exp_color;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fpga_clock);
    #1;
  endtask

  task automatic send(input logic [7:0] o, input int gap);
    gigatron_pixel_strobe = 1'b1;
    gigatron_out = o;
    last_strobe = cyc;
    tick();
    gigatron_pixel_strobe = 1'b0;
    repeat (gap - 1) tick();
  endtask

  // n hsync falling edges with sync otherwise high
  task automatic blank_lines(input int n);
    repeat (n) begin
      send(8'h80, 8);
      send(8'hC0, 8);
    end
  endtask

  // hsync fall followed by the 12 back-porch strobes; next strobe is x=0
  task automatic porch();
    send(8'h80, 8);
    repeat (12) send(8'hC0, 8);
  endtask

  function automatic logic [7:0] exp_px(input logic [7:0] color, input int x, input int y);
    return PATTERN_MODE ? (8'(x) ^ 8'(y)) : color;
  endfunction

  task automatic check_writes(input string name, input int start, input int n,
                              input int scyc, input logic [18:0] base, input logic [7:0] data);
    if (wa_q.size() >= start + n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, " addr"}, 32'(wa_q[start+i]), 32'(base) + 32'(i));
        chk({name, " data"}, 32'(wd_q[start+i]), 32'(data));
        chk({name, " cycle"}, 32'(wc_q[start+i] - scyc), 32'(1 + 2*i));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int s0;
    int dstart;

    vecs[0] = '{8'hC9, 19'd0,  8'h54};
    vecs[1] = '{8'hFF, 19'd4,  8'hFF};
    vecs[2] = '{8'hC0, 19'd8,  8'h00};
    vecs[3] = '{8'hC3, 19'd12, 8'hE0};
    vecs[4] = '{8'hCC, 19'd16, 8'h1C};
    vecs[5] = '{8'hF0, 19'd20, 8'h03};
    vecs[6] = '{8'hE6, 19'd24, 8'hAA};

    // reset state
    rst = 1'b1;
    gigatron_pixel_strobe = 1'b0;
    gigatron_out = 8'hFF;
    repeat (3) tick();
    chk("reset write_signal", 32'(framebuffer_write_signal), 0);
    chk("reset address", 32'(framebuffer_write_address), 0);
    chk("reset data", 32'(framebuffer_write_data), 0);
    chk("reset frame_done", 32'(capture_frame_done), 0);
    chk("reset overflow", 32'(capture_overflow), 0);
    rst = 1'b0;
    tick();

    // frame start: vsync low for two strobes
    dstart = done_q.size();
    send(8'h40, 8);
    s0 = last_strobe;
    send(8'h40, 8);
    chk("vsync1 done count", 32'(done_q.size() - dstart), 1);
    if (done_q.size() > dstart) chk("vsync1 done cycle", 32'(done_q[dstart] - s0), 1);
    chk("blank no writes", 32'(wa_q.size()), 0);

    blank_lines(32);
    porch();
    chk("porch no writes", 32'(wa_q.size()), 0);

    // line y=0, table-driven colours
    for (int i = 0; i < 7; i++) begin
      start = wa_q.size();
      send(vecs[i].out, 8);
      chk($sformatf("px%0d count", i), 32'(wa_q.size() - start), 4);
      check_writes($sformatf("px%0d", i), start, 4, last_strobe,
                   vecs[i].exp_base, exp_px(vecs[i].exp_color, i, 0));
    end
    chk("no overflow after line0", 32'(capture_overflow), 0);

    // line y=1: strobes 4 cycles apart, third pixel dropped
    porch();
    start = wa_q.size();
    send(8'hFF, 4);
    s0 = last_strobe;
    send(8'hC3, 4);
    send(8'hCC, 8);
    chk("ovf write count", 32'(wa_q.size() - start), 8);
    check_writes("ovf px0", start, 4, s0, 19'd640, exp_px(8'hFF, 0, 1));
    check_writes("ovf px1", start + 4, 4, s0 + 8, 19'd644, exp_px(8'hE0, 1, 1));
    chk("ovf flag", 32'(capture_overflow), 1);

    // line y=2: x=0..159 visible, x=160 not
    porch();
    start = wa_q.size();
    repeat (161) send(8'hFF, 8);
    chk("line2 write count", 32'(wa_q.size() - start), 640);
    if (wa_q.size() >= start + 640) begin
      chk("line2 first addr", 32'(wa_q[start]), 1280);
      chk("line2 last addr", 32'(wa_q[start+639]), 1919);
      chk("line2 last data", 32'(wd_q[start+639]), 32'(exp_px(8'hFF, 159, 2)));
    end

    // hsync and vsync fall together: frame done, line_base cleared, no stride
    dstart = done_q.size();
    send(8'h00, 8);
    s0 = last_strobe;
    chk("vsync2 done count", 32'(done_q.size() - dstart), 1);
    if (done_q.size() > dstart) chk("vsync2 done cycle", 32'(done_q[dstart] - s0), 1);
    send(8'hC0, 8);
    blank_lines(32);
    porch();
    start = wa_q.size();
    send(8'hFF, 8);
    chk("newframe count", 32'(wa_q.size() - start), 4);
    check_writes("newframe", start, 4, last_strobe, 19'd0, exp_px(8'hFF, 0, 0));

    // reset at phase 3 of a pixel on line y=1
    porch();
    chk("ovf still set", 32'(capture_overflow), 1);
    start = wa_q.size();
    gigatron_pixel_strobe = 1'b1;
    gigatron_out = 8'hFF;
    s0 = cyc;
    tick();
    gigatron_pixel_strobe = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst write_signal", 32'(framebuffer_write_signal), 0);
    chk("midrst address", 32'(framebuffer_write_address), 0);
    chk("midrst data", 32'(framebuffer_write_data), 0);
    chk("midrst frame_done", 32'(capture_frame_done), 0);
    chk("midrst overflow", 32'(capture_overflow), 0);
    rst = 1'b0;
    tick();
    chk("midrst write count", 32'(wa_q.size() - start), 2);
    check_writes("midrst", start, 2, s0, 19'd640, exp_px(8'hFF, 0, 1));

    // after reset nothing is captured until a vsync
    start = wa_q.size();
    blank_lines(40);
    porch();
    repeat (3) send(8'hFF, 8);
    chk("unarmed no writes", 32'(wa_q.size() - start), 0);

    dstart = done_q.size();
    send(8'h40, 8);
    s0 = last_strobe;
    chk("vsync3 done count", 32'(done_q.size() - dstart), 1);
    if (done_q.size() > dstart) chk("vsync3 done cycle", 32'(done_q[dstart] - s0), 1);
    blank_lines(32);
    porch();
    start = wa_q.size();
    send(8'hE6, 8);
    chk("rearmed count", 32'(wa_q.size() - start), 4);
    check_writes("rearmed", start, 4, last_strobe, 19'd0, exp_px(8'hAA, 0, 0));
    chk("final overflow", 32'(capture_overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
